// File: rtl/mux2x1_stream.sv
// mux2x1_stream: two-channel valid/ready merge onto one registered output stage.
// Define MUX2X1_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to A.
module mux2x1_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_sel,
    input  logic             y_ready
);
    logic space, grant_a, grant_b;
`ifdef MUX2X1_ROUND_ROBIN_EN
    logic last;
    // under contention the channel that did not win last time goes next
    assign grant_a = a_valid && (!b_valid || last);
`else
    assign grant_a = a_valid;
`endif
    assign grant_b = b_valid && !grant_a;
    assign space   = !y_valid || y_ready;
    assign a_ready = !rst && en && space && grant_a;
    assign b_ready = !rst && en && space && grant_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= 1'b0;
`ifdef MUX2X1_ROUND_ROBIN_EN
            last    <= 1'b1;
`endif
        end else if (a_ready || b_ready) begin
            y_valid <= 1'b1;
            y_data  <= b_ready ? b_data : a_data;
            y_sel   <= b_ready;
`ifdef MUX2X1_ROUND_ROBIN_EN
            last    <= b_ready;
`endif
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux2x1_stream.sv
// tb_mux2x1_stream: directed and random checks of mux2x1_stream against a beat-level reference model.
module tb_mux2x1_stream;
    localparam int W = 8;
`ifdef MUX2X1_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic a_ready, b_ready, y_valid, y_sel;
    logic [W-1:0] y_data;
    int total = 0, bad = 0;
    logic m_yv, m_ys, m_last;
    logic [W-1:0] m_yd;
    logic [W:0] q[$];

    mux2x1_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_sel(y_sel), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic av, input logic [W-1:0] ad,
                         input logic bv, input logic [W-1:0] bd, input logic yr);
        en = e; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_y_sel", y_sel, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        m_yv = 1'b0; m_yd = '0; m_ys = 1'b0; m_last = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // one clock: check readies before the edge, advance the model, check outputs after it
    task automatic cyc();
        int g;
        logic ea, eb, hold, hs;
        logic [W-1:0] hd;
        logic [W:0] exp_beat;
        #1;
        if (a_valid && b_valid) g = RR ? (m_last ? 0 : 1) : 0;
        else g = a_valid ? 0 : (b_valid ? 1 : -1);
        ea = en && (!m_yv || y_ready) && g == 0;
        eb = en && (!m_yv || y_ready) && g == 1;
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        if (m_yv && y_ready) begin
            check("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_beat = q.pop_front();
                check("sb_beat", {y_sel, y_data}, exp_beat);
            end
        end
        hold = y_valid && !y_ready; hd = y_data; hs = y_sel;
        if (ea || eb) begin
            q.push_back({eb, eb ? b_data : a_data});
            m_yv = 1'b1; m_yd = eb ? b_data : a_data; m_ys = eb; m_last = eb;
        end else if (y_ready) begin
            m_yv = 1'b0;
        end
        @(posedge clk);
        #1;
        check("y_valid", y_valid, m_yv);
        if (m_yv) begin
            check("y_data", y_data, m_yd);
            check("y_sel", y_sel, m_ys);
        end
        if (hold) begin
            check("stall_data", y_data, hd);
            check("stall_sel", y_sel, hs);
        end
    endtask

    initial begin
        do_reset();
        // single A beat
        drive(1, 1, 8'h3C, 0, 8'h00, 1); cyc();
        check("t1_beat", {y_valid, y_sel, y_data}, {1'b1, 1'b0, 8'h3C});
        drive(1, 0, 8'h00, 0, 8'h00, 1); cyc();
        check("t1_drain", y_valid, 0);
        // contention
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 8'h11, 1, 8'h22, 1); cyc();
            check("t2_sel", y_sel, RR ? i % 2 : 0);
            check("t2_data", y_data, (RR && i % 2) ? 8'h22 : 8'h11);
        end
        // backpressure
        do_reset();
        drive(1, 0, 8'h00, 1, 8'h5A, 1); cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h77, 0, 8'h00, 0); cyc();
            check("t3_hold", {y_valid, y_sel, y_data}, {1'b1, 1'b1, 8'h5A});
        end
        drive(1, 1, 8'h77, 0, 8'h00, 1); cyc();
        check("t3_next", {y_valid, y_sel, y_data}, {1'b1, 1'b0, 8'h77});
        // enable low drains pending beat without accepting
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h33, 1, 8'h44, 1); cyc();
            check("t4_idle", y_valid, 0);
        end
        drive(1, 1, 8'h33, 1, 8'h44, 1); cyc();
        check("t4_resume", y_valid, 1);
        // async reset with a pending beat
        drive(1, 1, 8'hFF, 0, 8'h00, 1); cyc();
        check("t5_loaded", y_data, 8'hFF);
        do_reset();
        drive(1, 1, 8'hA1, 1, 8'hB2, 1); cyc();
        check("t5_first", {y_sel, y_data}, {1'b0, 8'hA1});
        // random traffic
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(9) != 0, $urandom_range(1), W'($urandom),
                  $urandom_range(1), W'($urandom), $urandom_range(9) < 7);
            cyc();
        end
        drive(0, 0, 8'h00, 0, 8'h00, 1); cyc(); cyc();
        check("sb_final_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux2x1_stream.md
# mux2x1_stream

Two-input, one-output stream multiplexer with a valid/ready handshake on every channel and a registered output stage. It merges two producer channels (A = index 0, B = index 1) onto one consumer channel, with arbitration and a one-entry output holding register. It is the merge-side counterpart of the 1x2 demultiplexer and rejoins streams that the demultiplexer split. Each output beat carries the index of the channel it came from.

## Interface
Parameters:
- WIDTH, 8, data width of every channel

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; low = no new beats accepted, holding register still drains
- a_valid  input  1  channel A beat present
- a_data  input  WIDTH  channel A payload
- a_ready  output  1  channel A beat accepted this cycle
- b_valid  input  1  channel B beat present
- b_data  input  WIDTH  channel B payload
- b_ready  output  1  channel B beat accepted this cycle
- y_valid  output  1  output beat present (registered)
- y_data  output  WIDTH  output payload (registered)
- y_sel  output  1  source of current output beat, 0 = A, 1 = B (registered)
- y_ready  input  1  consumer accepts output beat

One clock domain only. Reset is asynchronous and active-high.

## Operation
- Transfer rule: a beat moves on any channel only in a cycle where valid && ready is sampled high at the clk edge.
- `space = !y_valid || y_ready`. The holding register can load this cycle; this is a pass-through of y_ready, with no bubble at full throughput.
- Grant is combinational from a_valid, b_valid and the priority state `last`. `last` is 1 bit, and its reset value is 1 so that A has priority first.
  - Only one channel valid: that channel is granted.
  - Both valid: the channel != last is granted.
  - Neither valid: no grant.
- `a_ready = en && space && grant_A`. `b_ready = en && space && grant_B`. At most one of them is ever high.
- Loading the holding register on an accepted beat:
  - y_data is set to the granted channel's data.
  - y_sel is set to the granted index.
  - y_valid is set to 1.
  - `last` is set to the granted index.
- On y_valid && y_ready with no new accept, y_valid clears to 0. y_data and y_sel hold their last values (don't-care).
- When y_ready is high and a new beat is accepted in the same cycle, the register reloads. y_valid stays 1.
- While y_valid && !y_ready, y_data and y_sel must not change (output stability). Both a_ready and b_ready are 0.
- en = 0: both readies are 0 and `last` is frozen. A pending output beat still completes when y_ready is high.
- Readies may depend combinationally on a_valid, b_valid and y_ready. Valids must not depend on readies.

## Timing
- Reset (async assert, sampled deassert): y_valid = 0, y_data = 0, y_sel = 0, last = 1. During reset a_ready = 0 and b_ready = 0.
- Latency: an input beat accepted at edge N is visible on y_* in the cycle after edge N (1 cycle).
- Throughput: 1 beat per cycle when y_ready is held high. With both inputs continuously valid, beats alternate A, B, A, B…
- Reset asserted mid-transfer: the pending output beat is discarded and no partial state remains. After deassert, the first grant under contention goes to A.
- Simultaneous a_valid/b_valid rise in the first cycle after reset: A is granted.

## Configuration
- `MUX2X1_ROUND_ROBIN_EN` defined: round-robin arbitration via `last`, as described above.
- `MUX2X1_ROUND_ROBIN_EN` undefined: fixed priority, A always wins under contention. The `last` register is removed and B is granted only when a_valid = 0. All handshake and timing rules are unchanged.

## Test plan
- Reset, then a single A beat 0x3C with y_ready = 1: a_ready = 1 in the accept cycle; next cycle y_valid = 1, y_data = 0x3C, y_sel = 0; then y_valid = 0.
- Both channels continuously valid (A = 0x11, B = 0x22) with y_ready = 1 for 6 cycles:
  - Round-robin build: output sequence A, B, A, B, A, B.
  - Fixed-priority build: all 6 beats are A 0x11, and b_ready never rises.
- Backpressure: load B 0x5A, then hold y_ready = 0 for 4 cycles while A is valid: y_data stays 0x5A and y_sel stays 1; a_ready = 0 throughout. On y_ready = 1, A is accepted the same cycle and appears next.
- en = 0 with both inputs valid and one beat already pending: the pending beat drains when y_ready = 1, both readies stay 0, and no new beat appears until en = 1.
- Reset asserted while y_valid = 1 (y_data = 0xFF): y_valid drops immediately (async). After release, both valid: A is granted first.
- Random valids and y_ready for 10k cycles with a scoreboard: no beat is lost or duplicated, per-channel order is preserved, y_sel always matches the source, and y_data/y_sel stay stable under stall.
